// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control side of an in-order RV32 pipeline. It decodes the ID-slot
// instruction into control flags, then carries the fields and flags through
// DEPTH registered stages (stage 0 = EX ... DEPTH-1 = WB). It also inserts
// load-use bubbles, handles branch-redirect flushes of the ID slot, and runs a
// small mul/div handshake FSM that freezes the pipe while the unit is busy.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   id_valid, id_opcode/funct3/funct7  ID-slot instruction
//   id_rd, id_rs1, id_rs2              ID-slot register addresses
//   stall_ext                          memory-side stall, freezes all stages
//   flush                              drop the ID-slot instruction
//   md_done                            mul/div result ready (pulse)
//   id_ready                           ID instruction consumed this cycle (comb)
//   md_start                           launch pulse for the md op in stage 0
//   stg_*                              per-stage valid, fields and decoded flags
module ctrl_pipe #(
  parameter int unsigned DEPTH          = 3,
  parameter bit          ENABLE_M       = 1'b1,
  parameter bit          LOAD_USE_STALL = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [6:0]             id_opcode,
  input  logic [2:0]             id_funct3,
  input  logic [6:0]             id_funct7,
  input  logic [4:0]             id_rd,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic                   stall_ext,
  input  logic                   flush,
  input  logic                   md_done,
  output logic                   id_ready,
  output logic                   md_start,
  output logic [DEPTH-1:0]       stg_valid,
  output logic [DEPTH-1:0][6:0]  stg_opcode,
  output logic [DEPTH-1:0][2:0]  stg_funct3,
  output logic [DEPTH-1:0][6:0]  stg_funct7,
  output logic [DEPTH-1:0][4:0]  stg_rd,
  output logic [DEPTH-1:0]       stg_load_regfile,
  output logic [DEPTH-1:0]       stg_is_load,
  output logic [DEPTH-1:0]       stg_is_md,
  output logic [DEPTH-1:0]       stg_illegal
);

  localparam int unsigned OPC_W = 7;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned F7_W  = 7;
  localparam int unsigned REG_W = 5;

  localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_REG    = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_FENCE  = 7'b0001111;
  localparam logic [OPC_W-1:0] OP_SYSTEM = 7'b1110011;

  localparam logic [F7_W-1:0] F7_BASE = 7'b0000000;
  localparam logic [F7_W-1:0] F7_ALT  = 7'b0100000;
  localparam logic [F7_W-1:0] F7_MD   = 7'b0000001;

  typedef struct packed {
    logic             valid;
    logic [OPC_W-1:0] opcode;
    logic [F3_W-1:0]  funct3;
    logic [F7_W-1:0]  funct7;
    logic [REG_W-1:0] rd;
    logic             load_regfile;
    logic             is_load;
    logic             is_md;
    logic             illegal;
  } stage_t;

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

  stage_t    stg_q [DEPTH];
  stage_t    id_entry;
  md_state_t md_state_q;
  logic      op_known;
  logic      op_writes;
  logic      op_reg;
  logic      dec_md;
  logic      dec_illegal;
  logic      md_hold;
  logic      hold;
  logic      load_use;

  // Opcode classification: known opcodes, and those that write rd.
  always_comb begin
    op_known  = 1'b0;
    op_writes = 1'b0;
    case (id_opcode)
      OP_LUI, OP_AUIPC, OP_LOAD, OP_IMM, OP_REG, OP_JAL, OP_JALR: begin
        op_known  = 1'b1;
        op_writes = 1'b1;
      end
      OP_STORE, OP_BRANCH, OP_FENCE, OP_SYSTEM: op_known = 1'b1;
      default: ;
    endcase
  end

  assign op_reg      = (id_opcode == OP_REG);
  assign dec_md      = ENABLE_M && op_reg && (id_funct7 == F7_MD);
  assign dec_illegal = !op_known ||
                       (op_reg && !((id_funct7 == F7_BASE) || (id_funct7 == F7_ALT) || dec_md));

  // Stage-0 candidate built from the ID slot.
  always_comb begin
    id_entry              = '0;
    id_entry.valid        = id_valid;
    id_entry.opcode       = id_opcode;
    id_entry.funct3       = id_funct3;
    id_entry.funct7       = id_funct7;
    id_entry.rd           = id_rd;
    id_entry.load_regfile = op_writes && (id_rd != 5'd0) && !dec_illegal;
    id_entry.is_load      = (id_opcode == OP_LOAD);
    id_entry.is_md        = dec_md;
    id_entry.illegal      = dec_illegal;
  end

  assign md_start = (md_state_q == MD_IDLE) && stg_q[0].valid && stg_q[0].is_md;

  // Mul/div freeze; in DONE the only remaining hold source is stall_ext itself.
  always_comb begin
    md_hold = 1'b0;
    case (md_state_q)
      MD_IDLE: md_hold = md_start;
      MD_BUSY: md_hold = !md_done;
      MD_DONE: md_hold = 1'b0;
      default: md_hold = 1'b0;
    endcase
  end

  assign hold     = stall_ext || md_hold;
  assign load_use = LOAD_USE_STALL && id_valid && stg_q[0].valid && stg_q[0].is_load &&
                    (stg_q[0].rd != 5'd0) &&
                    ((stg_q[0].rd == id_rs1) || (stg_q[0].rd == id_rs2));
  assign id_ready = flush || (!hold && !load_use);

  // Stage registers: shift on advance; stage 0 takes a bubble on flush/load-use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(DEPTH); k++) stg_q[k] <= '0;
    end else if (!hold) begin
      for (int k = 1; k < int'(DEPTH); k++) stg_q[k] <= stg_q[k-1];
      stg_q[0] <= (flush || load_use || !id_valid) ? '0 : id_entry;
    end
  end

  // Mul/div handshake: launch, wait for done, absorb done under stall_ext.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_state_q <= MD_IDLE;
    end else begin
      case (md_state_q)
        MD_IDLE: if (md_start) md_state_q <= MD_BUSY;
        MD_BUSY: if (md_done) md_state_q <= stall_ext ? MD_DONE : MD_IDLE;
        MD_DONE: if (!stall_ext) md_state_q <= MD_IDLE;
        default: md_state_q <= MD_IDLE;
      endcase
    end
  end

  // Flatten stage registers onto the per-stage output buses.
  always_comb begin
    for (int k = 0; k < int'(DEPTH); k++) begin
      stg_valid[k]        = stg_q[k].valid;
      stg_opcode[k]       = stg_q[k].opcode;
      stg_funct3[k]       = stg_q[k].funct3;
      stg_funct7[k]       = stg_q[k].funct7;
      stg_rd[k]           = stg_q[k].rd;
      stg_load_regfile[k] = stg_q[k].load_regfile;
      stg_is_load[k]      = stg_q[k].is_load;
      stg_is_md[k]        = stg_q[k].is_md;
      stg_illegal[k]      = stg_q[k].illegal;
    end
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed bench for ctrl_pipe. Two instances share stimulus:
// u_m (ENABLE_M=1) and u_nm (ENABLE_M=0). A reference model of the pipeline
// (list of stage entries plus a "mul/div outstanding" record) is checked on
// every falling edge; directed literal expectations pin the model.
module tb_ctrl_pipe;
  localparam int D = 3;

  localparam logic [6:0] OP_LOAD = 7'h03;
  localparam logic [6:0] OP_IMM  = 7'h13;
  localparam logic [6:0] OP_REG  = 7'h33;

  logic clk = 1'b0;
  logic rst_n, id_valid, stall_ext, flush, md_done;
  logic [6:0] id_opcode, id_funct7;
  logic [2:0] id_funct3;
  logic [4:0] id_rd, id_rs1, id_rs2;

  logic             id_ready_o [2];
  logic             md_start_o [2];
  logic [D-1:0]     s_valid [2];
  logic [D-1:0][6:0] s_op   [2];
  logic [D-1:0][2:0] s_f3   [2];
  logic [D-1:0][6:0] s_f7   [2];
  logic [D-1:0][4:0] s_rd   [2];
  logic [D-1:0]     s_lr [2];
  logic [D-1:0]     s_ld [2];
  logic [D-1:0]     s_md [2];
  logic [D-1:0]     s_il [2];

  always #5 clk = ~clk;

  ctrl_pipe #(.DEPTH(D), .ENABLE_M(1'b1), .LOAD_USE_STALL(1'b1)) u_m (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct3(id_funct3), .id_funct7(id_funct7), .id_rd(id_rd), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .stall_ext(stall_ext), .flush(flush), .md_done(md_done),
    .id_ready(id_ready_o[0]), .md_start(md_start_o[0]), .stg_valid(s_valid[0]),
    .stg_opcode(s_op[0]), .stg_funct3(s_f3[0]), .stg_funct7(s_f7[0]), .stg_rd(s_rd[0]),
    .stg_load_regfile(s_lr[0]), .stg_is_load(s_ld[0]), .stg_is_md(s_md[0]),
    .stg_illegal(s_il[0]));

  ctrl_pipe #(.DEPTH(D), .ENABLE_M(1'b0), .LOAD_USE_STALL(1'b1)) u_nm (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct3(id_funct3), .id_funct7(id_funct7), .id_rd(id_rd), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .stall_ext(stall_ext), .flush(flush), .md_done(md_done),
    .id_ready(id_ready_o[1]), .md_start(md_start_o[1]), .stg_valid(s_valid[1]),
    .stg_opcode(s_op[1]), .stg_funct3(s_f3[1]), .stg_funct7(s_f7[1]), .stg_rd(s_rd[1]),
    .stg_load_regfile(s_lr[1]), .stg_is_load(s_ld[1]), .stg_is_md(s_md[1]),
    .stg_illegal(s_il[1]));

  int n_chk  = 0;
  int n_pass = 0;
  int starts0 = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Instruction semantics: returns {writes_rd, is_load, is_md, illegal}.
  function automatic bit [3:0] decode(input bit en_m, input bit [6:0] op,
                                      input bit [6:0] f7, input bit [4:0] rd);
    bit known, writes, md, il;
    case (op)
      7'h37, 7'h17, 7'h03, 7'h13, 7'h33, 7'h6f, 7'h67: begin known = 1; writes = 1; end
      7'h23, 7'h63, 7'h0f, 7'h73:                      begin known = 1; writes = 0; end
      default:                                         begin known = 0; writes = 0; end
    endcase
    md = en_m && (op == 7'h33) && (f7 == 7'h01);
    il = !known || ((op == 7'h33) && !((f7 == 7'h00) || (f7 == 7'h20) || md));
    return {writes && (rd != 5'd0) && !il, op == 7'h03, md, il};
  endfunction

  // Reference model: per instance, list of stage entries and md bookkeeping.
  bit       mv  [2][D];
  bit [6:0] mop [2][D];
  bit [2:0] mf3 [2][D];
  bit [6:0] mf7 [2][D];
  bit [4:0] mrd [2][D];
  bit [3:0] mfl [2][D];
  bit       m_waiting [2];  // md launched, result not yet returned
  bit       m_parked  [2];  // result returned while memory stalled

  always begin : compare
    bit start, adv, haz;
    @(negedge clk);
    if (md_start_o[0] === 1'b1) starts0++;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        for (int k = 0; k < D; k++) mv[i][k] = 0;
        m_waiting[i] = 0;
        m_parked[i]  = 0;
      end
      start = !m_waiting[i] && !m_parked[i] && mv[i][0] && mfl[i][0][1];
      adv   = !stall_ext && !start && !(m_waiting[i] && !md_done);
      haz   = mv[i][0] && mfl[i][0][2] && (mrd[i][0] != 0) && id_valid &&
              ((mrd[i][0] == id_rs1) || (mrd[i][0] == id_rs2));
      chk($sformatf("u%0d id_ready", i), 32'(id_ready_o[i]), 32'(flush || (adv && !haz)));
      chk($sformatf("u%0d md_start", i), 32'(md_start_o[i]), 32'(start));
      for (int k = 0; k < D; k++) begin
        chk($sformatf("u%0d stg%0d valid", i, k), 32'(s_valid[i][k]), 32'(mv[i][k]));
        if (mv[i][k])
          chk($sformatf("u%0d stg%0d fields", i, k),
              32'({s_op[i][k], s_f3[i][k], s_f7[i][k], s_rd[i][k],
                   s_lr[i][k], s_ld[i][k], s_md[i][k], s_il[i][k]}),
              32'({mop[i][k], mf3[i][k], mf7[i][k], mrd[i][k], mfl[i][k]}));
      end
      if (rst_n) begin
        if (adv) begin
          for (int k = D - 1; k > 0; k--) begin
            mv[i][k] = mv[i][k-1]; mop[i][k] = mop[i][k-1]; mf3[i][k] = mf3[i][k-1];
            mf7[i][k] = mf7[i][k-1]; mrd[i][k] = mrd[i][k-1]; mfl[i][k] = mfl[i][k-1];
          end
          mv[i][0] = id_valid && !flush && !haz;
          mop[i][0] = id_opcode; mf3[i][0] = id_funct3; mf7[i][0] = id_funct7;
          mrd[i][0] = id_rd;
          mfl[i][0] = decode(i == 0, id_opcode, id_funct7, id_rd);
        end
        if (start) m_waiting[i] = 1;
        else if (m_waiting[i] && md_done) begin
          m_waiting[i] = 0;
          m_parked[i]  = stall_ext;
        end else if (m_parked[i] && !stall_ext) m_parked[i] = 0;
      end
    end
  end

  task automatic set_id(input bit v, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2);
    id_valid = v; id_opcode = op; id_funct3 = f3; id_funct7 = f7;
    id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
  endtask

  task automatic idle();
    set_id(0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [6:0] tbl_op [5];
  logic [6:0] tbl_f7 [5];
  int st;

  initial begin : stim
    rst_n = 0; stall_ext = 0; flush = 0; md_done = 0;
    idle();
    tick(); tick();
    chk("reset valid", 32'(s_valid[0]), 32'h0);
    chk("reset id_ready", 32'(id_ready_o[0]), 32'h1);
    chk("reset md_start", 32'(md_start_o[0]), 32'h0);
    rst_n = 1;

    // add x1; lw x2; addi x3 stream
    set_id(1, OP_REG, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0); tick();
    chk("stream v1", 32'(s_valid[0]), 32'b001);
    set_id(1, OP_LOAD, 3'd2, 7'h00, 5'd2, 5'd0, 5'd0); tick();
    chk("stream v2", 32'(s_valid[0]), 32'b011);
    set_id(1, OP_IMM, 3'd0, 7'h00, 5'd3, 5'd0, 5'd0); tick();
    chk("stream v3", 32'(s_valid[0]), 32'b111);
    chk("stream rd wb", 32'(s_rd[0][2]), 32'd1);
    chk("stream rd ex", 32'(s_rd[0][0]), 32'd3);
    chk("stream lr", 32'(s_lr[0]), 32'b111);
    chk("stream ld", 32'(s_ld[0]), 32'b010);
    idle(); repeat (3) tick();

    // decode corner table: unknown, sub, lui x0, store, reg funct7 illegal
    tbl_op[0] = 7'h7f; tbl_f7[0] = 7'h00;
    tbl_op[1] = 7'h33; tbl_f7[1] = 7'h20;
    tbl_op[2] = 7'h37; tbl_f7[2] = 7'h00;
    tbl_op[3] = 7'h23; tbl_f7[3] = 7'h00;
    tbl_op[4] = 7'h33; tbl_f7[4] = 7'h02;
    for (int j = 0; j < 5; j++) begin
      set_id(1, tbl_op[j], 3'd0, tbl_f7[j], (j == 2) ? 5'd0 : 5'd4, 5'd0, 5'd0);
      tick();
    end
    chk("bad funct7 illegal", 32'(s_il[0][0]), 32'h1);
    chk("bad funct7 no wb", 32'(s_lr[0][0]), 32'h0);
    chk("lui x0 no wb", 32'(s_lr[0][2]), 32'h0);
    idle(); repeat (3) tick();

    // load-use: lw x5 then add x6,x5,x1
    set_id(1, OP_LOAD, 3'd2, 7'h00, 5'd5, 5'd0, 5'd0); tick();
    set_id(1, OP_REG, 3'd0, 7'h00, 5'd6, 5'd5, 5'd1); #1;
    chk("lu id_ready", 32'(id_ready_o[0]), 32'h0);
    tick();
    chk("lu bubble", 32'(s_valid[0][1:0]), 32'b10);
    chk("lu id_ready after", 32'(id_ready_o[0]), 32'h1);
    tick();
    chk("lu add rd", 32'(s_rd[0][0]), 32'd6);
    chk("lu add valid", 32'(s_valid[0][0]), 32'h1);
    idle(); tick();

    // mul x7 with done after 4 cycles
    st = starts0;
    set_id(1, OP_REG, 3'd0, 7'h01, 5'd7, 5'd1, 5'd2); tick();
    chk("nm mul illegal", 32'(s_il[1][0]), 32'h1);
    chk("nm mul no wb", 32'(s_lr[1][0]), 32'h0);
    chk("nm md_start", 32'(md_start_o[1]), 32'h0);
    set_id(1, OP_IMM, 3'd0, 7'h00, 5'd8, 5'd0, 5'd0); #1;
    chk("mul md_start", 32'(md_start_o[0]), 32'h1);
    chk("mul frozen ready", 32'(id_ready_o[0]), 32'h0);
    tick();
    chk("mul md_start once", 32'(md_start_o[0]), 32'h0);
    tick(); tick(); tick();
    chk("mul held", 32'(s_rd[0][0]), 32'd7);
    md_done = 1; #1;
    chk("mul done ready", 32'(id_ready_o[0]), 32'h1);
    tick(); md_done = 0;
    chk("mul advanced", 32'(s_rd[0][1]), 32'd7);
    chk("mul follower", 32'(s_rd[0][0]), 32'd8);
    chk("mul start count", 32'(starts0 - st), 32'd1);
    idle(); tick(); tick();

    // back-to-back mul x13, mul x14
    set_id(1, OP_REG, 3'd0, 7'h01, 5'd13, 5'd0, 5'd0); tick();
    set_id(1, OP_REG, 3'd0, 7'h01, 5'd14, 5'd0, 5'd0); tick(); tick();
    md_done = 1; tick(); md_done = 0;
    idle(); #1;
    chk("b2b second start", 32'(md_start_o[0]), 32'h1);
    chk("b2b second rd", 32'(s_rd[0][0]), 32'd14);
    tick(); tick();
    md_done = 1; tick(); md_done = 0; tick(); tick();

    // md_done under stall_ext -> parked, single advance on release
    st = starts0;
    set_id(1, OP_REG, 3'd0, 7'h01, 5'd9, 5'd0, 5'd0); tick();
    idle(); tick(); tick();
    stall_ext = 1; md_done = 1; tick(); md_done = 0;
    chk("park held rd", 32'(s_rd[0][0]), 32'd9);
    tick(); tick();
    chk("park no restart", 32'(md_start_o[0]), 32'h0);
    stall_ext = 0; #1;
    chk("park release ready", 32'(id_ready_o[0]), 32'h1);
    tick();
    chk("park advanced", 32'(s_rd[0][1]), 32'd9);
    chk("park ex empty", 32'(s_valid[0][0]), 32'h0);
    tick();
    chk("park start count", 32'(starts0 - st), 32'd1);

    // flush during stall, flush on advance, flush beats load-use
    stall_ext = 1; flush = 1;
    set_id(1, OP_IMM, 3'd0, 7'h00, 5'd10, 5'd0, 5'd0); #1;
    chk("flush stall ready", 32'(id_ready_o[0]), 32'h1);
    tick(); tick();
    stall_ext = 0; flush = 0; idle(); tick();
    chk("flush stall dropped", 32'(s_valid[0][0]), 32'h0);
    set_id(1, OP_IMM, 3'd0, 7'h00, 5'd11, 5'd0, 5'd0); flush = 1; tick();
    flush = 0; idle();
    chk("flush adv bubble", 32'(s_valid[0][0]), 32'h0);
    set_id(1, OP_LOAD, 3'd2, 7'h00, 5'd5, 5'd0, 5'd0); tick();
    set_id(1, OP_REG, 3'd0, 7'h00, 5'd6, 5'd5, 5'd0); flush = 1; #1;
    chk("flush over lu ready", 32'(id_ready_o[0]), 32'h1);
    tick(); flush = 0; idle(); tick();

    // reset while mul/div busy
    set_id(1, OP_REG, 3'd0, 7'h01, 5'd12, 5'd0, 5'd0); tick();
    idle(); tick(); tick();
    rst_n = 0; #1;
    chk("rst busy valid", 32'(s_valid[0]), 32'h0);
    chk("rst busy md_start", 32'(md_start_o[0]), 32'h0);
    tick(); rst_n = 1; tick();
    md_done = 1; tick(); md_done = 0;
    chk("rst no start", 32'(md_start_o[0]), 32'h0);
    chk("rst stray done ready", 32'(id_ready_o[0]), 32'h1);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
